// File: rtl/ramp_adc_ctrl_pkg.sv
// Shared types and helpers for the single-slope ramp ADC controller.
package ramp_adc_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the flattened per-channel result bus.
  function automatic int bus_width(input int channels, input int width);
    return channels * width;
  endfunction

endpackage

// File: rtl/ramp_adc_ctrl_if.sv
// Bus between the ADC controller and its user: conversion request,
// comparator inputs, ramp drive and conversion results.
//
// Protocol: start is a level request with no ready; it is only sampled
// while the controller is idle (busy=0) and ignored otherwise. busy is high
// from the first RAMP cycle through the DONE cycle; done pulses for exactly
// one cycle, and codes/overflow are valid from that cycle until the edge
// that accepts the next start.
interface ramp_adc_ctrl_if
  import ramp_adc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                                     start;
  logic [CHANNELS-1:0]                      cmp;
  logic                                     ramp_en;
  logic [WIDTH-1:0]                         ramp_code;
  logic                                     busy;
  logic                                     done;
  logic [bus_width(CHANNELS, WIDTH)-1:0]    codes;
  logic [CHANNELS-1:0]                      overflow;

  // Side that requests conversions and consumes results.
  modport master (
    output start, cmp,
    input  ramp_en, ramp_code, busy, done, codes, overflow
  );

  // The controller itself.
  modport slave (
    input  start, cmp,
    output ramp_en, ramp_code, busy, done, codes, overflow
  );
endinterface

// File: rtl/ramp_adc_ctrl_channel.sv
// One comparator channel: latches the ramp code at its first trip and
// reports overflow if it never tripped before the conversion ended.
module ramp_adc_channel #(
  parameter int WIDTH    = 8,
  parameter int MAX_CODE = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,     // new conversion accepted
  input  logic             sample_i,    // controller is ramping
  input  logic             finalize_i,  // last ramp cycle
  input  logic             cmp_i,
  input  logic [WIDTH-1:0] ramp_code_i,
  output logic             hit_o,       // latched already or latching now
  output logic [WIDTH-1:0] code_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_CODE);

  logic             latched_q, latched_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic             overflow_q, overflow_d;

  // Capture on first trip; a trip on the final cycle beats the overflow fill.
  always_comb begin
    latched_d  = latched_q;
    code_d     = code_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      latched_d  = 1'b0;
      code_d     = '0;
      overflow_d = 1'b0;
    end else if (sample_i && !latched_q) begin
      if (cmp_i) begin
        latched_d = 1'b1;
        code_d    = ramp_code_i;
      end else if (finalize_i) begin
        code_d     = MAX_Q;
        overflow_d = 1'b1;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      latched_q  <= 1'b0;
      code_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      latched_q  <= latched_d;
      code_q     <= code_d;
      overflow_q <= overflow_d;
    end
  end

  assign hit_o      = latched_q | (sample_i & cmp_i);
  assign code_o     = code_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ramp_adc_ctrl.sv
// Single-slope ADC controller: runs one shared digital ramp and lets each
// column channel capture the code at which its comparator first trips.
module ramp_adc_ctrl
  import ramp_adc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int MAX_CODE   = 2**WIDTH - 1,
  parameter int EARLY_STOP = 0
) (
  input  logic              clk,
  input  logic              reset,
  ramp_adc_ctrl_if.slave    bus,
  output state_e            state_o   // debug view of the controller state
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_CODE);
  localparam bit               ES    = (EARLY_STOP != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ramp_code_q, ramp_code_d;

  logic                           accept;
  logic                           ramping;
  logic                           end_cond;
  logic                           finalize;
  logic [CHANNELS-1:0]            hit_w;
  logic [CHANNELS-1:0]            ovf_w;
  logic [CHANNELS-1:0][WIDTH-1:0] code_w;

  assign accept   = (state_q == IDLE) && bus.start;
  assign ramping  = (state_q == RAMP);
  // A channel tripping on the ending cycle still counts toward all-latched.
  assign end_cond = (ramp_code_q == MAX_Q) || (ES && (&hit_w));
  assign finalize = ramping && end_cond;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ramp_code_q <= '0;
    end else begin
      state_q     <= state_d;
      ramp_code_q <= ramp_code_d;
    end
  end

  // Next-state and ramp counter; the counter freezes on the last ramp code.
  always_comb begin
    state_d     = state_q;
    ramp_code_d = ramp_code_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RAMP;
          ramp_code_d = '0;
        end
      end
      RAMP: begin
        if (end_cond) state_d = DONE;
        else          ramp_code_d = ramp_code_q + WIDTH'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.ramp_en = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state_q)
      RAMP: begin
        bus.ramp_en = 1'b1;
        bus.busy    = 1'b1;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    ramp_adc_channel #(
      .WIDTH    (WIDTH),
      .MAX_CODE (MAX_CODE)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (accept),
      .sample_i    (ramping),
      .finalize_i  (finalize),
      .cmp_i       (bus.cmp[c]),
      .ramp_code_i (ramp_code_q),
      .hit_o       (hit_w[c]),
      .code_o      (code_w[c]),
      .overflow_o  (ovf_w[c])
    );
  end

  assign bus.ramp_code = ramp_code_q;
  assign bus.codes     = code_w;
  assign bus.overflow  = ovf_w;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ramp_adc_ctrl.sv
module tb_ramp_adc_ctrl;
  import ramp_adc_pkg::*;

  localparam int W  = 4;
  localparam int CH = 2;
  localparam int MC = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start_s;
  logic [CH-1:0] cmp_s;
  state_e        st0, st1;

  ramp_adc_ctrl_if #(.WIDTH(W), .CHANNELS(CH)) bus0 ();
  ramp_adc_ctrl_if #(.WIDTH(W), .CHANNELS(CH)) bus1 ();

  assign bus0.start = start_s;
  assign bus0.cmp   = cmp_s;
  assign bus1.start = start_s;
  assign bus1.cmp   = cmp_s;

  // Same stimulus goes to a full-length and an early-stop controller.
  ramp_adc_ctrl #(.WIDTH(W), .CHANNELS(CH), .MAX_CODE(MC), .EARLY_STOP(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .state_o(st0));
  ramp_adc_ctrl #(.WIDTH(W), .CHANNELS(CH), .MAX_CODE(MC), .EARLY_STOP(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .state_o(st1));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One conversion: trip codes per channel (>MC means never), comparator
  // behaviour after the trip, an optional stray start, and expected results.
  typedef struct {
    int           trip0;
    int           trip1;
    int           mode;        // 0 steady, 1 drop-then-rise, 2 random noise
    bit           extra_start;
    logic [W-1:0] code0;
    logic [W-1:0] code1;
    logic [CH-1:0] ovf;
    int           done_full;
    int           done_es;
    logic [W-1:0] rc_es;
  } vec_t;

  // Reference model: results follow from the trip codes alone.
  function automatic vec_t model(input int t0, input int t1, input int mode, input bit xs);
    vec_t v;
    int last;
    v.trip0 = t0; v.trip1 = t1; v.mode = mode; v.extra_start = xs;
    v.code0  = W'((t0 <= MC) ? t0 : MC);
    v.code1  = W'((t1 <= MC) ? t1 : MC);
    v.ovf    = {t1 > MC, t0 > MC};
    v.done_full = MC + 2;
    last = (t0 > t1) ? t0 : t1;
    if (last <= MC) begin
      v.done_es = last + 2;
      v.rc_es   = W'(last);
    end else begin
      v.done_es = MC + 2;
      v.rc_es   = W'(MC);
    end
    return v;
  endfunction

  function automatic logic cmp_level(input int r, input int trip, input int mode);
    if (r < trip)  return 1'b0;
    if (r == trip) return 1'b1;
    case (mode)
      1:       return (r >= trip + 4);
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic run_conv(input vec_t v, input string tag);
    int   trip[CH];
    int   done_at0 = 0, done_at1 = 0, done_n0 = 0, done_n1 = 0;
    int   ren0 = 0, ren1 = 0;
    bit   busy_ok0 = 1, busy_ok1 = 1, rc_ok0 = 1, rc_ok1 = 1;
    logic [W-1:0] e0, e1;
    trip[0] = v.trip0;
    trip[1] = v.trip1;
    @(negedge clk);
    start_s = 1'b1;
    cmp_s   = '0;
    @(posedge clk);                       // E0
    for (int k = 1; k <= MC + 4; k++) begin
      @(negedge clk);
      // observe cycle k
      if (bus0.done) begin done_n0++; if (done_at0 == 0) done_at0 = k; end
      if (bus1.done) begin done_n1++; if (done_at1 == 0) done_at1 = k; end
      if (bus0.ramp_en) ren0++;
      if (bus1.ramp_en) ren1++;
      if (bus0.busy !== (k <= v.done_full)) busy_ok0 = 0;
      if (bus1.busy !== (k <= v.done_es))   busy_ok1 = 0;
      if (k < v.done_full && bus0.ramp_code !== W'(k - 1)) rc_ok0 = 0;
      if (k < v.done_es   && bus1.ramp_code !== W'(k - 1)) rc_ok1 = 0;
      // drive for the edge closing cycle k (ramp code k-1)
      start_s = (k == 1) ? v.extra_start : 1'b0;
      for (int c = 0; c < CH; c++) cmp_s[c] = cmp_level(k - 1, trip[c], v.mode);
    end
    cmp_s = '0;
    check({tag, " done_cycle_full"}, done_at0, v.done_full);
    check({tag, " done_cycle_es"},   done_at1, v.done_es);
    check({tag, " done_pulses"},     {done_n1[15:0], done_n0[15:0]}, {16'd1, 16'd1});
    check({tag, " ramp_en_cycles"},  {ren1[15:0], ren0[15:0]},
          {16'(v.done_es - 1), 16'(v.done_full - 1)});
    check({tag, " busy_window"},     {busy_ok1, busy_ok0}, 2'b11);
    check({tag, " ramp_code_seq"},   {rc_ok1, rc_ok0}, 2'b11);
    check({tag, " final_ramp_code"}, {bus1.ramp_code, bus0.ramp_code}, {v.rc_es, W'(MC)});
    check({tag, " overflow"},        {bus1.overflow, bus0.overflow}, {v.ovf, v.ovf});
    exp_q.push_back(v.code0); exp_q.push_back(v.code1);
    exp_q.push_back(v.code0); exp_q.push_back(v.code1);
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
    check({tag, " codes_full"}, bus0.codes, {e1, e0});
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
    check({tag, " codes_es"},   bus1.codes, {e1, e0});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " dut0_outputs"},
          {bus0.ramp_en, bus0.busy, bus0.done, bus0.overflow, bus0.codes, bus0.ramp_code}, '0);
    check({tag, " dut1_outputs"},
          {bus1.ramp_en, bus1.busy, bus1.done, bus1.overflow, bus1.codes, bus1.ramp_code}, '0);
    check({tag, " states"}, {st1, st0}, {IDLE, IDLE});
  endtask

  // ---------------- test ----------------
  vec_t tbl[4];

  initial begin
    tbl[0] = '{5, 9, 0, 1'b0, 4'd5, 4'd9,  2'b00, 17, 11, 4'd9};
    tbl[1] = '{0, 16, 0, 1'b0, 4'd0, 4'd15, 2'b10, 17, 17, 4'd15};
    tbl[2] = '{0, 15, 0, 1'b0, 4'd0, 4'd15, 2'b00, 17, 17, 4'd15};
    tbl[3] = '{3, 7, 1, 1'b1, 4'd3, 4'd7,  2'b00, 17, 9,  4'd7};

    // Reset with random inputs.
    reset = 1'b1; start_s = 1'b0; cmp_s = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_s = 1'($urandom_range(0, 1));
      cmp_s   = CH'($urandom_range(0, 3));
    end
    @(negedge clk);
    check_all_zero("reset");
    start_s = 1'b0;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("post_reset_idle");

    // Directed table.
    for (int i = 0; i < 4; i++) run_conv(tbl[i], $sformatf("tbl%0d", i));

    // Reset in the middle of a ramp.
    begin
      int dones = 0;
      @(negedge clk); start_s = 1'b1; cmp_s = '0;
      @(posedge clk);
      for (int k = 1; k <= 7; k++) begin
        @(negedge clk);
        start_s = 1'b0;
        if (bus0.done | bus1.done) dones++;
      end
      check("midramp_code", {bus1.ramp_code, bus0.ramp_code}, {4'd6, 4'd6});
      reset = 1'b1;
      @(negedge clk);
      if (bus0.done | bus1.done) dones++;
      check_all_zero("midramp_reset");
      check("midramp_no_done", dones, 0);
      reset = 1'b0;
      run_conv(tbl[0], "after_reset");
    end

    // start held high: one IDLE cycle, then a fresh conversion with cleared results.
    begin
      int idle_seen = 0;
      @(negedge clk); start_s = 1'b1; cmp_s = '0;
      @(posedge clk);
      for (int k = 1; k <= MC + 3; k++) begin
        @(negedge clk);
        if (k == MC + 3) idle_seen = int'(bus0.busy);
      end
      check("b2b_idle_gap", idle_seen, 0);
      @(negedge clk);
      check("b2b_restart", {bus0.ramp_en, bus0.ramp_code, bus0.codes, bus0.overflow},
            {1'b1, 4'd0, 8'd0, 2'b00});
      start_s = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end

    // Randomized conversions against the model.
    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v = model($urandom_range(0, MC + 2), $urandom_range(0, MC + 2),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      run_conv(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
